// File: rtl/fifo_buff.sv
// Synchronous first-word-fall-through FIFO with occupancy count and sticky
// overflow/underflow flags. Head word is a combinational read of the memory.
module fifo_buff #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_ok, rd_ok, mem_we;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign r_data    = mem[r_ptr_q];

  always_comb begin
    // A simultaneous read frees the head slot, so a write while full still lands.
    wr_ok       = wr && (!full || rd);
    rd_ok       = rd && !empty;
    mem_we      = wr_ok && !reset;
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_ok) w_ptr_d = w_ptr_q + PTR_ONE;
    if (rd_ok) r_ptr_d = r_ptr_q + PTR_ONE;

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (wr && full && !rd) overflow_d = 1'b1;
    if (rd && empty)       underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never cleared, so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[w_ptr_q] <= w_data;
  end

endmodule

// File: tb/tb_fifo_buff.sv
// Directed self-checking bench for fifo_buff (default 16-bit x 8 words).
module tb_fifo_buff;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [15:0] w_data = '0;
  logic [15:0] r_data;
  logic        full, empty, overflow, underflow;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  fifo_buff #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .rd        (rd),
    .w_data    (w_data),
    .r_data    (r_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given controls; outputs sampled 1 time unit later.
  task automatic step(input logic s_wr, input logic s_rd, input logic [15:0] s_data);
    wr = s_wr;
    rd = s_rd;
    w_data = s_data;
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
    $display("step wr=%0b rd=%0b w_data=0x%04h -> count=%0d r_data=0x%04h full=%0b empty=%0b ovf=%0b unf=%0b",
             s_wr, s_rd, s_data, count, r_data, full, empty, overflow, underflow);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 16'h0000);
    reset = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();
    step(1'b0, 1'b0, 16'h0000);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_count", count, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_unf", underflow, 0);

    // Fill with 1..8, then drain in order
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 16'(i));
      chk("fill_count", count, i);
    end
    chk("fill_full", full, 1);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_data", r_data, i);
      step(1'b0, 1'b1, 16'h0000);
    end
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);

    // Fill with 0x11..0x18, then simultaneous read/write while full
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h0011 + 16'(i));
    chk("full2", full, 1);
    chk("rw_full_head", r_data, 16'h0011);
    step(1'b1, 1'b1, 16'h00AA);
    chk("rw_full_count", count, 8);
    chk("rw_full_ovf", overflow, 0);
    chk("rw_full_newhead", r_data, 16'h0012);

    // Write while full is dropped and flagged
    step(1'b1, 1'b0, 16'hBEEF);
    chk("ovf_count", count, 8);
    chk("ovf_flag", overflow, 1);
    for (int i = 0; i < 7; i++) begin
      chk("post_ovf_data", r_data, 16'h0012 + 16'(i));
      step(1'b0, 1'b1, 16'h0000);
    end
    chk("aa_eighth", r_data, 16'h00AA);
    step(1'b0, 1'b1, 16'h0000);
    chk("post_ovf_empty", empty, 1);
    chk("ovf_sticky", overflow, 1);

    // Read+write while empty: write only, underflow flagged
    step(1'b1, 1'b1, 16'h1234);
    chk("unf_flag", underflow, 1);
    chk("unf_count", count, 1);
    chk("unf_data", r_data, 16'h1234);
    chk("unf_empty", empty, 0);
    step(1'b0, 1'b1, 16'h0000);
    chk("unf_pop_empty", empty, 1);
    chk("unf_sticky", underflow, 1);

    // Wrap-around: push 5, pop 5, then 8 more words
    do_reset();
    chk("rst2_ovf", overflow, 0);
    chk("rst2_unf", underflow, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0100 + 16'(i));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h0000);
    chk("wrap_mid_empty", empty, 1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'hA000 + 16'(i));
    chk("wrap_full", full, 1);
    for (int i = 0; i < 8; i++) begin
      chk("wrap_data", r_data, 16'hA000 + 16'(i));
      step(1'b0, 1'b1, 16'h0000);
    end
    chk("wrap_empty", empty, 1);
    chk("wrap_unf", underflow, 0);

    // Reset mid-operation discards stored words
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0C00 + 16'(i));
    chk("pre_rst_count", count, 3);
    reset = 1'b1;
    step(1'b1, 1'b0, 16'hDEAD);
    reset = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    step(1'b1, 1'b0, 16'h5555);
    chk("post_rst_count", count, 1);
    chk("post_rst_data", r_data, 16'h5555);
    step(1'b0, 1'b1, 16'h0000);
    chk("post_rst_empty", empty, 1);
    chk("post_rst_unf", underflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_buff.md
Name: fifo_buff

Overview:
- Parametrised successor to the 16-bit pass-through buffer: a synchronous FIFO that stores words instead of passing them straight through.
- Decouples a producer (e.g. switch/debounced-input path) from a consumer (e.g. LED/7-seg display path).
- First-word-fall-through: the head word is always visible on r_data while empty = 0.
- Single clock domain; inferred as a register-file or distributed RAM.

Parameters:
- DATA_WIDTH, 16, word width in bits.
- ADDR_WIDTH, 3, pointer width; depth = 2**ADDR_WIDTH (8 words by default).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wr  input  1  write request; pushes w_data when accepted.
- rd  input  1  read request; pops the head word when accepted.
- w_data  input  DATA_WIDTH  data to push.
- r_data  output  DATA_WIDTH  head word (combinational read of the memory at r_ptr).
- full  output  1  high when the FIFO holds 2**ADDR_WIDTH words.
- empty  output  1  high when the FIFO holds 0 words.
- count  output  ADDR_WIDTH+1  current occupancy, 0 to 2**ADDR_WIDTH.
- overflow  output  1  sticky: set when wr is asserted while full and rd = 0.
- underflow  output  1  sticky: set when rd is asserted while empty.

Behaviour:
- Reset (clk edge with reset = 1):
  - w_ptr, r_ptr and count go to 0.
  - empty = 1, full = 0, overflow = 0, underflow = 0.
  - Memory contents are not cleared; r_data is don't-care while empty.
  - Reset overrides wr/rd in the same cycle.
  - Reset mid-operation discards all stored words.
- Pointers:
  - ADDR_WIDTH bits each; wrap modulo 2**ADDR_WIDTH with natural rollover.
  - count is kept as a separate register; full = (count == 2**ADDR_WIDTH), empty = (count == 0). Both are combinational from count.
- Accept rules, evaluated on each clk edge from pre-edge state:
  - wr=1, rd=0:
    - not full: mem[w_ptr] <= w_data; w_ptr++; count++.
    - full: write ignored; overflow <= 1.
  - wr=0, rd=1:
    - not empty: r_ptr++; count--.
    - empty: no change; underflow <= 1.
  - wr=1, rd=1:
    - empty: write only (w_ptr++, count++); the read is ignored; underflow <= 1.
    - full: both performed. The head is popped and the new word is written to the freed slot (w_ptr == r_ptr); both pointers advance; count unchanged; no overflow.
    - otherwise: both performed; count unchanged.
  - wr=0, rd=0: hold.
- Latency:
  - A word written at edge N is visible on r_data after edge N when the FIFO was empty. empty falls after edge N.
  - r_data changes combinationally after an accepted read advances r_ptr.
- Sticky flags stay set until reset; only reset clears them.
- No data corruption in any combination: ignored operations leave memory, pointers and count untouched.

Test Plan:
- Reset, then idle -> empty=1, full=0, count=0, overflow=0, underflow=0.
- Write 0x0001..0x0008 on 8 consecutive cycles (defaults) -> full=1 and count=8 after the 8th edge. Then read 8 cycles -> r_data sequence 0x0001..0x0008; empty=1 after the last read.
- While full, wr=1 with w_data=0xBEEF and rd=0 -> count stays 8, overflow=1. Subsequent reads never return 0xBEEF.
- While full, wr=1 and rd=1 with w_data=0x00AA -> head popped, count stays 8. The 8th subsequent read returns 0x00AA; overflow stays 0.
- While empty, rd=1 and wr=1 with w_data=0x1234 -> underflow=1, count=1, r_data=0x1234 after the edge.
- Wrap-around:
  - Push 5, pop 5, then push 8 words 0xA000..0xA007 -> all 8 read back in order, proving pointer wrap.
  - Assert reset with count=3 -> count=0, empty=1 on the next edge; a following write and read returns only the new word.
